// File: rtl/mem_dump_reader_pkg.sv
// Shared constants for the memory dump reader: FSM state encodings,
// word size in bytes and the checksum sentinel address.
package mem_dump_reader_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      READ = 3'd1,
      WAIT = 3'd2,
      SEND = 3'd3,
      DONE = 3'd4,
      CSUM = 3'd5
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Wide enough for any address width in use; the top slices it down.
   localparam logic [63:0] CSUM_SENTINEL = '1;

endpackage

// File: rtl/mem_dump_reader.sv
// Walks a word range of memory through a dedicated read port and streams each word
// over valid/ready. Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum word.
module mem_dump_reader
   import mem_dump_reader_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [ADDR_WIDTH-1:0]  base_addr,
   input  logic [COUNT_WIDTH-1:0] word_count,
   output logic                   mem_rd,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic [DATA_WIDTH-1:0]  mem_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_WIDTH-1:0]  out_addr,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   busy,
   output logic                   done
);

   state_t                 state_reg, state_next;
   logic [ADDR_WIDTH-1:0]  addr_reg, addr_next;
   logic [COUNT_WIDTH-1:0] count_reg, count_next;
   logic [ADDR_WIDTH-1:0]  mem_addr_reg;
   logic [ADDR_WIDTH-1:0]  out_addr_reg;
   logic [DATA_WIDTH-1:0]  out_data_reg;
   logic [ADDR_WIDTH-1:0]  aligned_base;
   state_t                 after_last;

   assign aligned_base = base_addr & ~ADDR_WIDTH'(WORD_BYTES - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_reg;
   assign after_last = CSUM;
`else
   assign after_last = DONE;
`endif

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      count_next = count_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               if (word_count != '0) begin
                  addr_next  = aligned_base;
                  count_next = word_count;
                  state_next = READ;
               end else begin
                  state_next = after_last;
               end
            end
         end
         READ: state_next = WAIT;
         WAIT: state_next = SEND;
         SEND: begin
            if (out_ready) begin
               count_next = count_reg - COUNT_WIDTH'(1);
               addr_next  = addr_reg + ADDR_WIDTH'(WORD_BYTES);
               state_next = (count_reg == COUNT_WIDTH'(1)) ? after_last : READ;
            end
         end
`ifdef MEM_DUMP_CHECKSUM_EN
         CSUM: begin
            if (out_ready) begin
               state_next = DONE;
            end
         end
`endif
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         addr_reg     <= '0;
         count_reg    <= '0;
         mem_addr_reg <= '0;
         out_addr_reg <= '0;
         out_data_reg <= '0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         count_reg <= count_next;
         // mem_addr only moves when a read is about to issue, so it holds otherwise.
         if (state_next == READ) begin
            mem_addr_reg <= addr_next;
         end
         if (state_reg == WAIT) begin
            out_addr_reg <= addr_reg;
            out_data_reg <= mem_rdata;
         end
      end
   end

`ifdef MEM_DUMP_CHECKSUM_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         csum_reg <= '0;
      end else if (state_reg == IDLE && start) begin
         csum_reg <= '0;
      end else if (state_reg == SEND && out_ready) begin
         csum_reg <= csum_reg ^ out_data_reg;
      end
   end

   assign out_valid = (state_reg == SEND) || (state_reg == CSUM);
   assign out_addr  = (state_reg == CSUM) ? CSUM_SENTINEL[ADDR_WIDTH-1:0] : out_addr_reg;
   assign out_data  = (state_reg == CSUM) ? csum_reg : out_data_reg;
   assign busy      = (state_reg == READ) || (state_reg == WAIT) ||
                      (state_reg == SEND) || (state_reg == CSUM);
`else
   assign out_valid = (state_reg == SEND);
   assign out_addr  = out_addr_reg;
   assign out_data  = out_data_reg;
   assign busy      = (state_reg == READ) || (state_reg == WAIT) || (state_reg == SEND);
`endif

   assign mem_rd   = (state_reg == READ);
   assign mem_addr = mem_addr_reg;
   assign done     = (state_reg == DONE);

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a small one-cycle-latency memory model.
// Expectations follow MEM_DUMP_CHECKSUM_EN when the bench is built with it.
module tb_mem_dump_reader;

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 0;
    logic        reset = 0;
    logic        start = 0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    mem_dump_reader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clock(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .word_count(word_count), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // 16-word memory, aliased over the address space by mem_addr[5:2].
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + i;
        mem[0]  = 32'h1111_1111;
        mem[1]  = 32'h2222_2222;
        mem[2]  = 32'h3333_3333;
        mem[15] = 32'hCAFE_F00D;
    end
    always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[5:2]];

    // Cycle counter and negedge monitor.
    int          cyc = 0;
    int          rd_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_valid_cyc = -1;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (mem_rd === 1'b1) rd_cnt++;
        if (out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            q_addr.push_back(out_addr);
            q_data.push_back(out_data);
            q_cyc.push_back(cyc);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        q_addr.delete();
        q_data.delete();
        q_cyc.delete();
        rd_cnt = 0;
        first_valid_cyc = -1;
        done_cyc = -1;
    endtask

    task automatic do_start(input logic [31:0] base, input logic [15:0] count, output int c0);
        @(posedge clk); #1;
        start = 1;
        base_addr = base;
        word_count = count;
        c0 = cyc;
        @(posedge clk); #1;
        start = 0;
        base_addr = 32'hDEAD_BEEF;
        word_count = 16'h0007;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({mem_rd, out_valid, busy, done, mem_addr, out_addr, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {mem_rd, out_valid, busy, done, mem_addr, out_addr, out_data});
        end
        reset = 1;
    endtask

    task automatic test_basic();
        int c0, d0;
        bit ok;
        logic [31:0] ea[3];
        logic [31:0] ed[3];
        ea = '{32'h0, 32'h4, 32'h8};
        ed = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        clear_mon();
        out_ready = 1;
        d0 = done_cnt;
        do_start(32'h0, 16'd3, c0);
        checks++;
        if (busy !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL basic_first_read got busy=%b rd=%b addr=%h exp busy=1 rd=1 addr=0", busy, mem_rd, mem_addr);
        end
        wait_done(d0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_done_timeout got=none exp=done pulse");
        end
        checks++;
        if (q_addr.size() != 3 + CS) begin
            failures++;
            $display("FAIL basic_word_count got=%0d exp=%0d", q_addr.size(), 3 + CS);
        end
        for (int i = 0; i < 3; i++) begin
            if (i < q_addr.size()) begin
                checks++;
                if (q_addr[i] !== ea[i] || q_data[i] !== ed[i]) begin
                    failures++;
                    $display("FAIL basic_word%0d got=%h/%h exp=%h/%h", i, q_addr[i], q_data[i], ea[i], ed[i]);
                end
            end
        end
        checks++;
        if (first_valid_cyc - c0 != 3) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=3", first_valid_cyc - c0);
        end
        if (q_cyc.size() >= 2) begin
            checks++;
            if (q_cyc[1] - q_cyc[0] != 3) begin
                failures++;
                $display("FAIL basic_throughput got=%0d exp=3", q_cyc[1] - q_cyc[0]);
            end
        end
        checks++;
        if (done_cyc - c0 != 10 + CS) begin
            failures++;
            $display("FAIL basic_done_cycle got=%0d exp=%0d", done_cyc - c0, 10 + CS);
        end
        checks++;
        if (rd_cnt != 3) begin
            failures++;
            $display("FAIL basic_reads got=%0d exp=3", rd_cnt);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b done=%b exp=0/0", busy, done);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (q_addr.size() > 3) begin
            checks++;
            if (q_addr[3] !== 32'hFFFF_FFFF || q_data[3] !== 32'h0) begin
                failures++;
                $display("FAIL basic_checksum got=%h/%h exp=ffffffff/00000000", q_addr[3], q_data[3]);
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        int c0, d0, stall_bad;
        bit ok, found;
        clear_mon();
        out_ready = 0;
        stall_bad = 0;
        d0 = done_cnt;
        do_start(32'h0, 16'd3, c0);
        for (int w = 0; w < 3; w++) begin
            found = 0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid === 1'b1) begin
                    found = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            checks++;
            if (!found) begin
                failures++;
                $display("FAIL bp_valid_timeout word%0d got=none exp=out_valid", w);
            end
            if (w == 1) begin
                for (int k = 0; k < 5; k++) begin
                    if (out_valid !== 1'b1 || out_data !== 32'h2222_2222 || out_addr !== 32'h4 || mem_rd !== 1'b0)
                        stall_bad++;
                    @(posedge clk); #1;
                end
            end
            out_ready = 1;
            @(posedge clk); #1;
            out_ready = 0;
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL bp_stall_hold got=%0d bad cycles exp=0", stall_bad);
        end
        out_ready = 1;
        wait_done(d0, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_done_timeout got=none exp=done pulse");
        end
        checks++;
        if (rd_cnt != 3) begin
            failures++;
            $display("FAIL bp_reads got=%0d exp=3", rd_cnt);
        end
        checks++;
        if (q_data.size() < 3 || q_data[0] !== 32'h1111_1111 || q_data[1] !== 32'h2222_2222 ||
            q_data[2] !== 32'h3333_3333 || q_addr[2] !== 32'h8) begin
            failures++;
            $display("FAIL bp_words got=%0d words exp=3 words 11111111/22222222/33333333", q_data.size());
        end
    endtask

    task automatic test_unaligned();
        int c0, d0;
        bit ok;
        clear_mon();
        out_ready = 1;
        d0 = done_cnt;
        do_start(32'h6, 16'd1, c0);
        checks++;
        if (mem_rd !== 1'b1 || mem_addr !== 32'h4) begin
            failures++;
            $display("FAIL unaligned_mem_addr got rd=%b addr=%h exp rd=1 addr=00000004", mem_rd, mem_addr);
        end
        wait_done(d0, ok);
        checks++;
        if (!ok || q_addr.size() != 1 + CS || q_addr[0] !== 32'h4 || q_data[0] !== 32'h2222_2222) begin
            failures++;
            $display("FAIL unaligned_word got=%0d words first=%h exp=%0d words 00000004/22222222",
                     q_addr.size(), (q_addr.size() > 0) ? q_addr[0] : 32'hx, 1 + CS);
        end
    endtask

    task automatic test_zero();
        int c0, d0;
        bit ok;
        clear_mon();
        out_ready = 1;
        d0 = done_cnt;
        do_start(32'h10, 16'd0, c0);
        wait_done(d0, ok);
        checks++;
        if (!ok || done_cyc - c0 != 1 + CS) begin
            failures++;
            $display("FAIL zero_done_cycle got=%0d exp=%0d", done_cyc - c0, 1 + CS);
        end
        checks++;
        if (rd_cnt != 0) begin
            failures++;
            $display("FAIL zero_no_read got=%0d exp=0", rd_cnt);
        end
        checks++;
        if (q_addr.size() != CS) begin
            failures++;
            $display("FAIL zero_words got=%0d exp=%0d", q_addr.size(), CS);
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (q_addr.size() > 0) begin
            checks++;
            if (q_addr[0] !== 32'hFFFF_FFFF || q_data[0] !== 32'h0) begin
                failures++;
                $display("FAIL zero_checksum got=%h/%h exp=ffffffff/00000000", q_addr[0], q_data[0]);
            end
        end
`else
        checks++;
        if (first_valid_cyc != -1) begin
            failures++;
            $display("FAIL zero_no_valid got=%0d exp=-1", first_valid_cyc);
        end
`endif
    endtask

    task automatic test_wrap();
        int c0, d0;
        bit ok;
        clear_mon();
        out_ready = 1;
        d0 = done_cnt;
        do_start(32'hFFFF_FFFC, 16'd2, c0);
        wait_done(d0, ok);
        checks++;
        if (!ok || q_addr.size() != 2 + CS) begin
            failures++;
            $display("FAIL wrap_words got=%0d exp=%0d", q_addr.size(), 2 + CS);
        end
        if (q_addr.size() >= 2) begin
            checks++;
            if (q_addr[0] !== 32'hFFFF_FFFC || q_data[0] !== 32'hCAFE_F00D) begin
                failures++;
                $display("FAIL wrap_word0 got=%h/%h exp=fffffffc/cafef00d", q_addr[0], q_data[0]);
            end
            checks++;
            if (q_addr[1] !== 32'h0 || q_data[1] !== 32'h1111_1111) begin
                failures++;
                $display("FAIL wrap_word1 got=%h/%h exp=00000000/11111111", q_addr[1], q_data[1]);
            end
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (q_addr.size() >= 3) begin
            checks++;
            if (q_data[2] !== (32'hCAFE_F00D ^ 32'h1111_1111)) begin
                failures++;
                $display("FAIL wrap_checksum got=%h exp=%h", q_data[2], 32'hCAFE_F00D ^ 32'h1111_1111);
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c0, d0;
        bit ok, found;
        clear_mon();
        out_ready = 0;
        d0 = done_cnt;
        do_start(32'h0, 16'd3, c0);
        for (int w = 0; w < 2; w++) begin
            found = 0;
            for (int i = 0; i < 10; i++) begin
                if (out_valid === 1'b1) begin
                    found = 1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (w == 0) begin
                out_ready = 1;
                @(posedge clk); #1;
                out_ready = 0;
            end
        end
        checks++;
        if (!found || out_data !== 32'h2222_2222) begin
            failures++;
            $display("FAIL rstmid_word2 got=%h exp=22222222", out_data);
        end
        reset = 0;
        #1;
        checks++;
        if ({mem_rd, out_valid, busy, done, mem_addr, out_addr, out_data} !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs got=%h exp=0",
                     {mem_rd, out_valid, busy, done, mem_addr, out_addr, out_data});
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1;
        checks++;
        if (done_cnt != d0) begin
            failures++;
            $display("FAIL rstmid_no_done got=%0d exp=%0d", done_cnt, d0);
        end
        clear_mon();
        out_ready = 1;
        d0 = done_cnt;
        do_start(32'h8, 16'd1, c0);
        wait_done(d0, ok);
        checks++;
        if (!ok || q_addr.size() != 1 + CS || q_addr[0] !== 32'h8 || q_data[0] !== 32'h3333_3333 || rd_cnt != 1) begin
            failures++;
            $display("FAIL rstmid_restart got=%0d words reads=%0d exp=%0d words 00000008/33333333 reads=1",
                     q_addr.size(), rd_cnt, 1 + CS);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_unaligned();
        test_zero();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
